anneal_sequencer: RTL and testbench

ANNEAL_SEQUENCER -- requirements
Module: anneal_sequencer

---
 rtl/replica_pkg.sv | 22 ++
 rtl/anneal_wait_timer.sv | 22 ++
 rtl/anneal_sequencer.sv | 167 ++++++++++++++++
 tb/tb_anneal_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/replica_pkg.sv
// Shared replica-exchange types: command encodings, sequencer state and default wait lengths.
package replica_pkg;

    typedef enum logic [1:0] {XCMD_NOP, XCMD_SELF, XCMD_PREV, XCMD_FOLW} exchange_command_t;
    typedef enum logic [1:0] {OPT_NOP, OPT_SWAP, OPT_FLIP, OPT_SHIFT} opt_command_t;

    typedef enum logic [3:0] {
        S_IDLE, S_RAND, S_RWAIT, S_DIST, S_DWAIT,
        S_METRO, S_EXCH, S_FOLW, S_XWAIT, S_DONE
    } anneal_seq_state_t;

    localparam int ANNEAL_RAND_WAIT = 20;
    localparam int ANNEAL_DIST_WAIT = 20;
    localparam int ANNEAL_XCH_WAIT  = 15;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/anneal_wait_timer.sv
// Down-counter shared by the sequencer's wait states; expire is high in the last wait cycle.
module anneal_wait_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          cnt <= '0;
        else if (load)       cnt <= load_val;
        else if (cnt != '0)  cnt <= cnt - W'(1);
    end

    assign expire = (cnt == W'(1));

endmodule

// File: rtl/anneal_sequencer.sv
// Annealing batch sequencer: RAND -> DIST -> METRO -> EXCH -> FOLW per iteration.
// Optional ANNEAL_SEQ_PAUSE_EN adds a pause input that holds the block at iteration boundaries.
module anneal_sequencer
    import replica_pkg::*;
#(
    parameter int RAND_WAIT = ANNEAL_RAND_WAIT,
    parameter int DIST_WAIT = ANNEAL_DIST_WAIT,
    parameter int XCH_WAIT  = ANNEAL_XCH_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
`ifdef ANNEAL_SEQ_PAUSE_EN
    input  logic              pause,
`endif
    input  logic [15:0]       iter_count,
    input  opt_command_t      opt_sel,
    input  exchange_command_t xcmd_even,
    input  exchange_command_t xcmd_odd,
    output logic              random_run,
    output logic              run_distance,
    output logic              run_command,
    output logic              exchange_valid,
    output opt_command_t      opt_com,
    output exchange_command_t c_exchange,
    output exchange_command_t c_metropolis,
    output logic              busy,
    output logic              done,
    output logic [15:0]       iter_left
);

    localparam int MAX_WAIT = max3(RAND_WAIT, DIST_WAIT, XCH_WAIT);
    localparam int CW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    anneal_seq_state_t state, state_d;
    logic [15:0]       iter_left_d;
    logic              load, expire, rand_fire, finish;
    logic [CW-1:0]     load_val;
    logic              pause_i;
    logic              par_base;
    opt_command_t      opt_lat, opt_src;
    exchange_command_t xe_lat, xo_lat;

`ifdef ANNEAL_SEQ_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    assign opt_src = (state == S_IDLE) ? opt_sel : opt_lat;

    anneal_wait_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    always_comb begin
        state_d     = state;
        iter_left_d = iter_left;
        load        = 1'b0;
        load_val    = '0;
        rand_fire   = 1'b0;
        finish      = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                if (iter_count == 16'd0) state_d = S_DONE;
                else begin
                    state_d     = S_RAND;
                    iter_left_d = iter_count;
                    rand_fire   = !pause_i;
                end
            end
            // RAND is held with outputs quiet until a cycle actually fires random_run
            S_RAND: if (random_run) begin
                if (RAND_WAIT == 0) state_d = S_DIST;
                else begin
                    state_d  = S_RWAIT;
                    load     = 1'b1;
                    load_val = CW'(RAND_WAIT);
                end
            end else rand_fire = !pause_i;
            S_RWAIT: if (expire) state_d = S_DIST;
            S_DIST: begin
                if (DIST_WAIT == 0) state_d = S_METRO;
                else begin
                    state_d  = S_DWAIT;
                    load     = 1'b1;
                    load_val = CW'(DIST_WAIT);
                end
            end
            S_DWAIT: if (expire) state_d = S_METRO;
            S_METRO: state_d = S_EXCH;
            S_EXCH:  state_d = S_FOLW;
            S_FOLW: begin
                if (XCH_WAIT == 0) finish = 1'b1;
                else begin
                    state_d  = S_XWAIT;
                    load     = 1'b1;
                    load_val = CW'(XCH_WAIT);
                end
            end
            S_XWAIT: if (expire) finish = 1'b1;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (finish) begin
            iter_left_d = (iter_left == 16'd0) ? 16'd0 : iter_left - 16'd1;
            if (iter_left_d != 16'd0) begin
                state_d   = S_RAND;
                rand_fire = !pause_i;
            end else state_d = S_DONE;
        end
        if (abort) begin
            state_d     = S_IDLE;
            iter_left_d = 16'd0;
            rand_fire   = 1'b0;
            load        = 1'b1;
            load_val    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            iter_left      <= 16'd0;
            par_base       <= 1'b0;
            opt_lat        <= OPT_NOP;
            xe_lat         <= XCMD_NOP;
            xo_lat         <= XCMD_NOP;
            random_run     <= 1'b0;
            run_distance   <= 1'b0;
            run_command    <= 1'b0;
            exchange_valid <= 1'b0;
            opt_com        <= OPT_NOP;
            c_exchange     <= XCMD_NOP;
            c_metropolis   <= XCMD_NOP;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state     <= state_d;
            iter_left <= iter_left_d;
            if (state == S_IDLE && start && !abort) begin
                par_base <= iter_count[0];
                opt_lat  <= opt_sel;
                xe_lat   <= xcmd_even;
                xo_lat   <= xcmd_odd;
            end
            random_run     <= rand_fire;
            opt_com        <= rand_fire ? opt_src : OPT_NOP;
            run_distance   <= (state_d == S_DIST);
            run_command    <= (state_d == S_EXCH);
            exchange_valid <= (state_d inside {S_DIST, S_DWAIT, S_METRO, S_EXCH, S_FOLW, S_XWAIT});
            // LSB of (iter_count - iter_left) is the XOR of the two LSBs
            c_exchange     <= (state_d != S_EXCH) ? XCMD_NOP :
                              ((par_base ^ iter_left[0]) ? xo_lat : xe_lat);
            c_metropolis   <= (state_d == S_METRO) ? XCMD_SELF :
                              (state_d == S_FOLW)  ? XCMD_FOLW : XCMD_NOP;
            busy           <= (state_d != S_IDLE);
            done           <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_anneal_sequencer.sv
// Directed bench for anneal_sequencer; pause scenario only when ANNEAL_SEQ_PAUSE_EN is defined.
module tb_anneal_sequencer;
    import replica_pkg::*;

    logic              clk = 1'b0;
    logic              reset, start, abort, pause;
    logic [15:0]       iter_count;
    opt_command_t      opt_sel;
    exchange_command_t xcmd_even, xcmd_odd;
    logic              random_run, run_distance, run_command, exchange_valid, busy, done;
    opt_command_t      opt_com;
    exchange_command_t c_exchange, c_metropolis;
    logic [15:0]       iter_left;
    int                checks = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    anneal_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
`ifdef ANNEAL_SEQ_PAUSE_EN
        .pause          (pause),
`endif
        .iter_count     (iter_count),
        .opt_sel        (opt_sel),
        .xcmd_even      (xcmd_even),
        .xcmd_odd       (xcmd_odd),
        .random_run     (random_run),
        .run_distance   (run_distance),
        .run_command    (run_command),
        .exchange_valid (exchange_valid),
        .opt_com        (opt_com),
        .c_exchange     (c_exchange),
        .c_metropolis   (c_metropolis),
        .busy           (busy),
        .done           (done),
        .iter_left      (iter_left)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int k, input logic rr, input logic rd,
                            input logic rc, input logic ev, input logic [1:0] oc,
                            input logic [1:0] cx, input logic [1:0] cm, input logic bs,
                            input logic dn, input logic [15:0] il);
        string t;
        t = $sformatf("%s@%0d", tag, k);
        chk({t, ".random_run"},     32'(random_run),     32'(rr));
        chk({t, ".run_distance"},   32'(run_distance),   32'(rd));
        chk({t, ".run_command"},    32'(run_command),    32'(rc));
        chk({t, ".exchange_valid"}, 32'(exchange_valid), 32'(ev));
        chk({t, ".opt_com"},        32'(opt_com),        32'(oc));
        chk({t, ".c_exchange"},     32'(c_exchange),     32'(cx));
        chk({t, ".c_metropolis"},   32'(c_metropolis),   32'(cm));
        chk({t, ".busy"},           32'(busy),           32'(bs));
        chk({t, ".done"},           32'(done),           32'(dn));
        chk({t, ".iter_left"},      32'(iter_left),      32'(il));
    endtask

    // Pulses start for one cycle; returns observing cycle T+1.
    task automatic start_batch(input logic [15:0] n);
        iter_count = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
        iter_count = 16'd0; opt_sel = OPT_FLIP; xcmd_even = XCMD_PREV; xcmd_odd = XCMD_FOLW;
        tick(); tick();
        chk_outs("reset", 0, 0, 0, 0, 0, OPT_NOP, XCMD_NOP, XCMD_NOP, 0, 0, 16'd0);
        reset = 1'b1;
        tick(); tick();

        // Single iteration timeline, with an ignored start mid-batch
        start_batch(16'd1);
        for (int k = 1; k <= 62; k++) begin
            if (k > 1) tick();
            chk_outs("single", k, k == 1, k == 22, k == 44, (k >= 22 && k <= 60),
                     (k == 1) ? OPT_FLIP : OPT_NOP,
                     (k == 44) ? XCMD_PREV : XCMD_NOP,
                     (k == 43) ? XCMD_SELF : ((k == 45) ? XCMD_FOLW : XCMD_NOP),
                     k <= 61, k == 61, (k <= 60) ? 16'd1 : 16'd0);
            if (k == 30) begin start = 1'b1; iter_count = 16'd9; end
            if (k == 31) start = 1'b0;
        end

        // Three iterations: alternating exchange commands, 60-cycle period
        tick();
        start_batch(16'd3);
        for (int k = 1; k <= 182; k++) begin
            if (k > 1) tick();
            chk($sformatf("multi@%0d.random_run", k), 32'(random_run),
                32'(k == 1 || k == 61 || k == 121));
            chk($sformatf("multi@%0d.c_exchange", k), 32'(c_exchange),
                32'((k == 44 || k == 164) ? XCMD_PREV : ((k == 104) ? XCMD_FOLW : XCMD_NOP)));
            chk($sformatf("multi@%0d.iter_left", k), 32'(iter_left),
                (k <= 60) ? 32'd3 : (k <= 120) ? 32'd2 : (k <= 180) ? 32'd1 : 32'd0);
            chk($sformatf("multi@%0d.done", k), 32'(done), 32'(k == 181));
        end

        // Zero-iteration batch
        tick();
        start_batch(16'd0);
        chk_outs("zero", 1, 0, 0, 0, 0, OPT_NOP, XCMD_NOP, XCMD_NOP, 1, 1, 16'd0);
        tick();
        chk_outs("zero", 2, 0, 0, 0, 0, OPT_NOP, XCMD_NOP, XCMD_NOP, 0, 0, 16'd0);

        // Abort in DWAIT of iteration 2 (DWAIT spans cycles 83..102)
        tick();
        start_batch(16'd3);
        for (int k = 2; k <= 90; k++) tick();
        chk("abort.pre.exchange_valid", 32'(exchange_valid), 32'd1);
        chk("abort.pre.iter_left", 32'(iter_left), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_outs("abort", 91, 0, 0, 0, 0, OPT_NOP, XCMD_NOP, XCMD_NOP, 0, 0, 16'd0);
        for (int k = 92; k <= 160; k++) begin
            tick();
            chk($sformatf("abort@%0d.done", k), 32'(done), 32'd0);
            chk($sformatf("abort@%0d.busy", k), 32'(busy), 32'd0);
        end
        start_batch(16'd1);
        for (int k = 1; k <= 61; k++) begin
            if (k > 1) tick();
            chk($sformatf("after_abort@%0d.random_run", k), 32'(random_run), 32'(k == 1));
            chk($sformatf("after_abort@%0d.done", k), 32'(done), 32'(k == 61));
        end

        // Asynchronous reset during XWAIT (cycles 46..60)
        tick();
        start_batch(16'd2);
        for (int k = 2; k <= 50; k++) tick();
        chk("rst.pre.exchange_valid", 32'(exchange_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk_outs("rst_async", 50, 0, 0, 0, 0, OPT_NOP, XCMD_NOP, XCMD_NOP, 0, 0, 16'd0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 70; k++) begin
            tick();
            chk($sformatf("rst_after@%0d.busy", k), 32'(busy), 32'd0);
            chk($sformatf("rst_after@%0d.random_run", k), 32'(random_run), 32'd0);
        end

`ifdef ANNEAL_SEQ_PAUSE_EN
        // Pause sampled on 10 edges at the iteration-2 boundary
        start_batch(16'd2);
        for (int k = 1; k <= 132; k++) begin
            if (k > 1) tick();
            chk($sformatf("pause@%0d.random_run", k), 32'(random_run), 32'(k == 1 || k == 71));
            chk($sformatf("pause@%0d.done", k), 32'(done), 32'(k == 131));
            if (k == 60) pause = 1'b1;
            if (k == 70) pause = 1'b0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
